stego_sequencer: RTL and testbench
==================================

STEGO_SEQUENCER -- requirements
Module: stego_sequencer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, width of size inputs and counters.
REQ-002 SHALL have port clk, input, 1; the single clock; all state on its rising edge.
REQ-003 SHALL have port reset, input, 1; asynchronous active-low reset.
REQ-004 SHALL have ports start (input, 1; level run request) and sgp_mode (input, 1; 0 = embed, 1 = extract).
REQ-005 SHALL have ports pixel_size, secret_size and output_size, each input, REG_WIDTH; beat counts, sampled at job launch.
REQ-006 SHALL have ports pix_valid (input, 1) and pix_ready (output, 1); the pixel stream handshake.
REQ-007 SHALL have ports sec_valid (input, 1) and sec_ready (output, 1); the secret-byte stream handshake.
REQ-008 SHALL have ports core_en (output, 1; datapath step strobe) and core_phase (output, 3; pixel index within a 6-pixel group).
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1); the result stream handshake.
REQ-010 SHALL have ports busy (output, 1), out_finish (output, 1) and error (output, 1).

Function
REQ-011 SHALL implement the states IDLE, LOAD, RUN, DRAIN and DONE.
REQ-012 SHALL, in IDLE with start=1, latch sgp_mode and the three sizes, then go to LOAD; if pixel_size=0, it SHALL go directly to DONE.
REQ-013 SHALL use LOAD for exactly 1 cycle: it clears pix_cnt, sec_cnt, out_cnt, phase and sec_held, then goes to RUN.
REQ-014 SHALL count a beat only when valid and ready are both 1 in the same cycle.
REQ-015 SHALL, in embed mode, assert sec_ready only in RUN with phase=0, !sec_held and sec_cnt<secret_size; a secret handshake sets sec_held and increments sec_cnt.
REQ-016 SHALL drive pix_ready=1 only in RUN with pix_cnt<pixel_size, (embed: sec_held=1 or sec_cnt=secret_size) and an output slot free (out_valid=0 or out_ready=1).
REQ-017 SHALL, on a pixel handshake: pulse core_en for that cycle, drive core_phase=phase, increment pix_cnt, and advance phase 0..5 with wrap to 0; in embed mode, phase 5 clears sec_held.
REQ-018 SHALL set out_valid 1 cycle after each pixel beat in embed mode, and 1 cycle after each phase-5 beat in extract mode; a partial final group produces no output.
REQ-019 SHALL hold out_valid until out_ready; each output handshake increments out_cnt; a new set and a handshake in the same cycle keep out_valid=1.
REQ-020 SHALL move from RUN to DRAIN when pix_cnt=pixel_size, and from DRAIN to DONE when out_valid=0.
REQ-021 SHALL assert error in DONE when out_cnt differs from the latched output_size; error stays set until the next LOAD.
REQ-022 SHALL hold out_finish=1 in DONE only, and return to IDLE when start=0.
REQ-023 SHALL treat start=0 in LOAD, RUN or DRAIN as an abort: next state IDLE, out_valid and sec_held cleared, out_finish not asserted.
REQ-024 SHALL drive busy=1 in LOAD, RUN and DRAIN.
REQ-025 SHALL keep all counters REG_WIDTH wide; they do not wrap, because pix_cnt stops at pixel_size.

Reset
REQ-026 SHALL, while reset=0, immediately force state IDLE and all counters, phase and sec_held to 0.
REQ-027 SHALL force every output to 0 during reset: pix_ready, sec_ready, core_en, core_phase, out_valid, busy, out_finish and error.
REQ-028 SHALL, on a mid-job reset, discard the job; the next job starts from LOAD only after start=1 is seen in IDLE.

Configuration
REQ-029 SHALL, when STEGO_SEQ_TIMEOUT_EN is defined, include a 16-bit stall counter.
REQ-030 SHALL clear the stall counter on any handshake; while busy=1 it increments every cycle, and reaching 65535 forces DONE with error=1.
REQ-031 SHALL, when STEGO_SEQ_TIMEOUT_EN is undefined, contain no stall counter and SHALL never time out.

Verification
REQ-032 SHALL cover embed with pixel_size=12, secret_size=2, output_size=12 and all valids/readys at 1: 2 secret beats, 12 core_en pulses with phase 0..5,0..5, 12 outputs, out_finish=1, error=0.
REQ-033 SHALL cover extract with pixel_size=13, secret_size=0, output_size=2: sec_ready is never asserted, outputs occur after pixels 6 and 12, pixel 13 gives no output, out_finish=1, error=0.
REQ-034 SHALL cover out_ready held at 0 for 5 cycles mid-embed: pix_ready is 0 throughout, out_valid stays 1 with stable count, and there is no loss or duplication.
REQ-035 SHALL cover start dropped after pixel 4: IDLE on the next cycle, out_valid=0, out_finish=0; a restart with pixel_size=6 completes normally.
REQ-036 SHALL cover reset asserted mid-RUN, asynchronously between clock edges: all outputs are 0 immediately; pixel_size=0 then goes directly to DONE with out_finish=1.
REQ-037 SHALL cover, with STEGO_SEQ_TIMEOUT_EN defined, pix_valid held at 0 in RUN: DONE and error=1 after 65535 stall cycles.

Source files
------------

// File: rtl/stego_sequencer.sv
// stego_sequencer: job sequencer for the steganography datapath.
// Paces pixel/secret streams, strobes the core, and emits results.
// Ports: clk, reset (async active-low), start, sgp_mode,
//   pixel_size/secret_size/output_size (beat counts),
//   pix_valid/pix_ready, sec_valid/sec_ready, core_en/core_phase,
//   out_valid/out_ready, busy, out_finish, error.
// Option: define STEGO_SEQ_TIMEOUT_EN for a 16-bit stall timeout.
module stego_sequencer #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sgp_mode,
    input  logic [REG_WIDTH-1:0] pixel_size,
    input  logic [REG_WIDTH-1:0] secret_size,
    input  logic [REG_WIDTH-1:0] output_size,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 sec_valid,
    output logic                 sec_ready,
    output logic                 core_en,
    output logic [2:0]           core_phase,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 out_finish,
    output logic                 error
);

    typedef enum logic [2:0] {
        IDLE, LOAD, RUN, DRAIN, DONE
    } state_t;

    localparam logic [REG_WIDTH-1:0] CNT_ONE =
        {{(REG_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_n;
    logic                 mode_q;
    logic [REG_WIDTH-1:0] psize_q, ssize_q, osize_q;
    logic [REG_WIDTH-1:0] pix_cnt_q, sec_cnt_q, out_cnt_q;
    logic [2:0]           phase_q;
    logic                 sec_held_q, ov_q, err_q;
    logic                 pix_hs, sec_hs, out_hs, out_set;
    logic                 abort, launch;
`ifdef STEGO_SEQ_TIMEOUT_EN
    logic [15:0]          stall_q;
    logic                 timeout;
`endif

    always_comb begin
        state_n    = state_q;
        pix_ready  = 1'b0;
        sec_ready  = 1'b0;
        busy       = 1'b0;
        out_finish = 1'b0;
        abort      = 1'b0;
        launch     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_n = (pixel_size == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (!start) abort = 1'b1;
                else        state_n = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                sec_ready = !mode_q && (phase_q == 3'd0) &&
                            !sec_held_q && (sec_cnt_q < ssize_q);
                // embed needs its secret byte in hand before pixels flow
                pix_ready = (pix_cnt_q < psize_q) &&
                            (mode_q || sec_held_q ||
                             (sec_cnt_q == ssize_q)) &&
                            (!ov_q || out_ready);
                if (!start)                     abort = 1'b1;
                else if (pix_cnt_q == psize_q)  state_n = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!start)     abort = 1'b1;
                else if (!ov_q) state_n = DONE;
            end
            DONE: begin
                out_finish = 1'b1;
                if (!start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
`ifdef STEGO_SEQ_TIMEOUT_EN
        timeout = busy && !abort && (stall_q == 16'hFFFF);
        if (timeout) state_n = DONE;
`endif
    end

    assign pix_hs     = pix_valid & pix_ready;
    assign sec_hs     = sec_valid & sec_ready;
    assign out_hs     = ov_q & out_ready;
    // extract emits one result per full 6-pixel group
    assign out_set    = pix_hs & (!mode_q | (phase_q == 3'd5));
    assign core_en    = pix_hs;
    assign core_phase = pix_hs ? phase_q : 3'd0;
    assign out_valid  = ov_q;
    assign error      = err_q |
                        ((state_q == DONE) && (out_cnt_q != osize_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            psize_q    <= '0;
            ssize_q    <= '0;
            osize_q    <= '0;
            pix_cnt_q  <= '0;
            sec_cnt_q  <= '0;
            out_cnt_q  <= '0;
            phase_q    <= 3'd0;
            sec_held_q <= 1'b0;
            ov_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_n;
            if (launch) begin
                mode_q    <= sgp_mode;
                psize_q   <= pixel_size;
                ssize_q   <= secret_size;
                osize_q   <= output_size;
                out_cnt_q <= '0;
            end
            if (state_q == LOAD) begin
                pix_cnt_q  <= '0;
                sec_cnt_q  <= '0;
                out_cnt_q  <= '0;
                phase_q    <= 3'd0;
                sec_held_q <= 1'b0;
                ov_q       <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                if (sec_hs) begin
                    sec_held_q <= 1'b1;
                    sec_cnt_q  <= sec_cnt_q + CNT_ONE;
                end
                if (pix_hs) begin
                    pix_cnt_q <= pix_cnt_q + CNT_ONE;
                    phase_q   <= (phase_q == 3'd5) ? 3'd0
                                                   : phase_q + 3'd1;
                    if (!mode_q && (phase_q == 3'd5))
                        sec_held_q <= 1'b0;
                end
                if (out_hs)
                    out_cnt_q <= out_cnt_q + CNT_ONE;
                if (abort) begin
                    ov_q       <= 1'b0;
                    sec_held_q <= 1'b0;
                end else if (out_set) begin
                    ov_q <= 1'b1;
                end else if (out_hs) begin
                    ov_q <= 1'b0;
                end
                if (error)
                    err_q <= 1'b1;
`ifdef STEGO_SEQ_TIMEOUT_EN
                if (timeout)
                    err_q <= 1'b1;
`endif
            end
        end
    end

`ifdef STEGO_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_q <= 16'd0;
        else if (!busy || pix_hs || sec_hs || out_hs)
            stall_q <= 16'd0;
        else
            stall_q <= stall_q + 16'd1;
    end
`endif

endmodule

// File: tb/tb_stego_sequencer.sv
// tb_stego_sequencer: directed scoreboard bench for stego_sequencer.
// Stimulus pushes expected phases/result origins; a monitor checks.
module tb_stego_sequencer;

    localparam int W = 32;

    logic         clk, reset, start, sgp_mode;
    logic [W-1:0] pixel_size, secret_size, output_size;
    logic         pix_valid, pix_ready, sec_valid, sec_ready;
    logic         core_en, out_valid, out_ready;
    logic [2:0]   core_phase;
    logic         busy, out_finish, error;

    stego_sequencer #(.REG_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .sgp_mode(sgp_mode),
        .pixel_size(pixel_size), .secret_size(secret_size),
        .output_size(output_size),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .sec_valid(sec_valid), .sec_ready(sec_ready),
        .core_en(core_en), .core_phase(core_phase),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .out_finish(out_finish), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int q_phase[$];
    int q_src[$];
    int pix_seen = 0, sec_seen = 0, out_seen = 0;
    int job_p, job_s, job_o;
    logic prev_ov = 1'b0, prev_hs = 1'b0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // result origin = pixel count when a fresh result appears
    always @(negedge clk) begin
        if (!reset) begin
            prev_ov = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (out_valid && (!prev_ov || prev_hs)) begin
                if (q_src.size() == 0) chk("out_extra", 1, 0);
                else chk("out_src", pix_seen, q_src.pop_front());
            end
            if (out_valid && !out_ready)
                chk("stall_pix_ready", pix_ready, 0);
            if (core_en) begin
                if (q_phase.size() == 0) chk("pix_extra", 1, 0);
                else chk("core_phase", core_phase, q_phase.pop_front());
                pix_seen++;
            end
            if (sec_valid && sec_ready) sec_seen++;
            if (out_valid && out_ready) out_seen++;
            prev_ov = out_valid;
            prev_hs = out_valid && out_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit m, input int ps, input int ss,
                          input int os);
        job_p = pix_seen;
        job_s = sec_seen;
        job_o = out_seen;
        for (int k = 0; k < ps; k++) q_phase.push_back(k % 6);
        for (int k = 1; k <= ps; k++)
            if (!m || (k % 6 == 0)) q_src.push_back(job_p + k);
        sgp_mode    = m;
        pixel_size  = W'(ps);
        secret_size = W'(ss);
        output_size = W'(os);
        start       = 1'b1;
    endtask

    task automatic finish(input string nm, input int eo, input int es,
                          input int ep, input bit ee);
        int n;
        n = 0;
        while (!out_finish && n < 500) begin
            step();
            n++;
        end
        chk({nm, "_finish"}, out_finish, 1);
        chk({nm, "_error"}, error, ee);
        chk({nm, "_outs"}, out_seen - job_o, eo);
        chk({nm, "_secs"}, sec_seen - job_s, es);
        chk({nm, "_pixs"}, pix_seen - job_p, ep);
        chk({nm, "_q_left"}, q_src.size() + q_phase.size(), 0);
        start = 1'b0;
        step();
        chk({nm, "_idle"}, {busy, out_finish, out_valid}, 0);
    endtask

    task automatic wait_pix(input int cnt);
        int n;
        n = 0;
        while ((pix_seen - job_p) < cnt && n < 200) begin
            step();
            n++;
        end
        chk("wait_pix", (pix_seen - job_p) >= cnt, 1);
    endtask

    int hold;

    initial begin
        reset = 1'b0; start = 1'b0; sgp_mode = 1'b0;
        pixel_size = '0; secret_size = '0; output_size = '0;
        pix_valid = 1'b0; sec_valid = 1'b0; out_ready = 1'b0;
        #2;
        chk("reset_outs", {pix_ready, sec_ready, core_en, core_phase,
                           out_valid, busy, out_finish, error}, 0);
        pix_valid = 1'b1; sec_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();

        launch(0, 12, 2, 12);
        finish("embed", 12, 2, 12, 0);

        launch(1, 13, 0, 2);
        finish("extract", 2, 0, 13, 0);

        launch(0, 12, 2, 12);
        wait_pix(3);
        out_ready = 1'b0;
        hold = out_seen;
        repeat (5) begin
            step();
            chk("stall_ov", out_valid, 1);
        end
        chk("stall_count", out_seen, hold);
        out_ready = 1'b1;
        finish("stall", 12, 2, 12, 0);

        launch(0, 12, 2, 12);
        wait_pix(4);
        start = 1'b0;
        pix_valid = 1'b0;
        step();
        chk("abort_idle", {busy, out_valid, out_finish}, 0);
        chk("abort_pixs", pix_seen - job_p, 4);
        q_phase.delete();
        q_src.delete();
        pix_valid = 1'b1;
        step();
        launch(0, 6, 1, 6);
        finish("restart", 6, 1, 6, 0);

        launch(0, 6, 1, 5);
        finish("mismatch", 6, 1, 6, 1);
        chk("err_hold", error, 1);
        launch(1, 6, 0, 1);
        finish("extract6", 1, 0, 6, 0);

        launch(0, 12, 2, 12);
        wait_pix(3);
        #2 reset = 1'b0;
        #1;
        chk("rst_async", {pix_ready, sec_ready, core_en, core_phase,
                          out_valid, busy, out_finish, error}, 0);
        start = 1'b0;
        q_phase.delete();
        q_src.delete();
        step();
        reset = 1'b1;
        step();
        chk("rst_idle", {busy, out_finish}, 0);
        launch(0, 0, 0, 0);
        finish("zero", 0, 0, 0, 0);

`ifdef STEGO_SEQ_TIMEOUT_EN
        pix_valid = 1'b0;
        launch(1, 12, 0, 2);
        begin
            int n;
            n = 0;
            while (!out_finish && n < 70000) begin
                step();
                n++;
            end
            chk("tmo_cycles_min", n >= 65535, 1);
        end
        chk("tmo_finish", out_finish, 1);
        chk("tmo_error", error, 1);
        q_phase.delete();
        q_src.delete();
        start = 1'b0;
        step();
        pix_valid = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
